// File: rtl/mult4_seq_pkg.sv
// Shared types and helpers for the 4x4 multiplier operand sequencer.
// Operand pair bundle, FSM state encoding and product check.
package mult4_seq_pkg;

  localparam int OPW = 4;
  localparam int PW  = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } seq_state_t;

  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
  } op_pair_t;

  function automatic logic prod_bad(
    input logic [OPW-1:0] a,
    input logic [OPW-1:0] b,
    input logic [PW-1:0]  p
  );
    logic [PW-1:0] ea;
    logic [PW-1:0] eb;
    logic [PW-1:0] ref_p;
    ea    = {{(PW-OPW){1'b0}}, a};
    eb    = {{(PW-OPW){1'b0}}, b};
    ref_p = ea * eb;
    return p != ref_p;
  endfunction

endpackage

// File: rtl/mult4_op_fifo.sv
// Synchronous operand-pair FIFO, no bypass.
// Full only clears after a pop has been registered.
module mult4_op_fifo
  import mult4_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  logic     pop_i,
  input  op_pair_t wdata_i,
  output logic     full_o,
  output logic     empty_o,
  output op_pair_t rdata_o
);

  localparam int AW = $clog2(DEPTH);

  op_pair_t        mem_q [DEPTH];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [AW:0]     cnt_q;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mult4_op_sequencer.sv
// Operand queue, launch FSM, timeout and result collector
// around a 4x4 sequential shift-add multiplier.
module mult4_op_sequencer
  import mult4_seq_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic          blif_clk_net,
  input  logic          blif_reset_net,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [OPW-1:0] in_a,
  input  logic [OPW-1:0] in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OPW-1:0] out_a,
  output logic [OPW-1:0] out_b,
  output logic [PW-1:0]  out_p,
  output logic          out_err,
  output logic [OPW-1:0] mul_a,
  output logic [OPW-1:0] mul_b,
  output logic          mul_start,
  input  logic          mul_ready,
  input  logic [PW-1:0]  mul_p,
  output logic          busy,
  output logic          timeout_err,
  output logic          prod_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  seq_state_t     state_q;
  logic [TW-1:0]  timer_q;
  logic [TW-1:0]  timer_d;
  logic           tmo_hit;
  logic [OPW-1:0] mul_a_q;
  logic [OPW-1:0] mul_b_q;
  logic           mul_start_q;
  logic           out_valid_q;
  logic [OPW-1:0] out_a_q;
  logic [OPW-1:0] out_b_q;
  logic [PW-1:0]  out_p_q;
  logic           out_err_q;
  logic           timeout_q;
  logic           prod_err_q;

  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           can_launch;
  logic           drain;
  logic           chk_bad;
  op_pair_t       fifo_rdata;
  op_pair_t       fifo_wdata;

  assign in_ready   = ~fifo_full;
  assign push       = in_valid & ~fifo_full;
  assign drain      = out_valid_q & out_ready;
  assign can_launch = ~fifo_empty & mul_ready
                    & (~out_valid_q | out_ready);
  assign pop        = (state_q == IDLE) & can_launch;
  assign fifo_wdata = '{a: in_a, b: in_b};
  assign timer_d    = timer_q + 1'b1;
  assign tmo_hit    = (timer_d == TW'(TIMEOUT_CYC));
  assign chk_bad    = prod_bad(mul_a_q, mul_b_q, mul_p);

  mult4_op_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (blif_clk_net),
    .rst_i   (blif_reset_net),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (fifo_wdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .rdata_o (fifo_rdata)
  );

  // Launch/wait FSM with timeout, result register and sticky flags.
  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_p_q     <= '0;
      out_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      prod_err_q  <= 1'b0;
    end else begin
      mul_start_q <= 1'b0;
      if (drain) out_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (can_launch) begin
            state_q     <= LAUNCH;
            mul_a_q     <= fifo_rdata.a;
            mul_b_q     <= fifo_rdata.b;
            mul_start_q <= 1'b1;
            timer_q     <= '0;
          end
        end
        LAUNCH: begin
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          timer_q <= timer_d;
          if (tmo_hit) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else if (!mul_ready) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          timer_q <= timer_d;
          if (mul_ready) begin
            out_valid_q <= 1'b1;
            out_a_q     <= mul_a_q;
            out_b_q     <= mul_b_q;
            out_p_q     <= mul_p;
            out_err_q   <= chk_bad;
            prod_err_q  <= prod_err_q | chk_bad;
            state_q     <= IDLE;
          end else if (tmo_hit) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
      endcase
    end
  end

  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign mul_start   = mul_start_q;
  assign out_valid   = out_valid_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_p       = out_p_q;
  assign out_err     = out_err_q;
  assign timeout_err = timeout_q;
  assign prod_err    = prod_err_q;
  assign busy        = (state_q != IDLE) | ~fifo_empty;

endmodule
